// File: rtl/line_address_gen_if.sv
// Request and beat channels between the cache controller, this generator
// and the memory-side bus.
interface line_address_gen_if #(
  parameter int instruction_size = 64,
  parameter int data_lines       = 6,
  parameter int capacity         = 14,
  parameter int associativity    = 3,
  parameter int beat_bytes       = 3
);
  localparam int IW = capacity - associativity;
  localparam int TW = instruction_size - data_lines - IW;
  localparam int BW = data_lines - beat_bytes;

  logic                        req_valid;
  logic                        req_ready;
  logic [TW-1:0]               req_tag;
  logic [IW-1:0]               req_index;
  logic [data_lines-1:0]       req_offset;
  logic                        req_wrap;
  logic                        addr_valid;
  logic                        addr_ready;
  logic [instruction_size-1:0] addr_out;
  logic [BW-1:0]               addr_beat;
  logic                        addr_last;

  modport slave (
    input  req_valid, req_tag, req_index,
    input  req_offset, req_wrap, addr_ready,
    output req_ready, addr_valid, addr_out,
    output addr_beat, addr_last
  );

  modport master (
    output req_valid, req_tag, req_index,
    output req_offset, req_wrap, addr_ready,
    input  req_ready, addr_valid, addr_out,
    input  addr_beat, addr_last
  );
endinterface

// File: rtl/line_address_gen.sv
// Burst address generator: one full byte address per bus beat of a
// cache line, sequential or critical-word-first wrapping order.
module line_address_gen #(
  parameter int instruction_size = 64,
  parameter int data_lines       = 6,
  parameter int capacity         = 14,
  parameter int associativity    = 3,
  parameter int beat_bytes       = 3
) (
  input  logic              clk,
  input  logic              reset,
  line_address_gen_if.slave bus,
  output logic              busy
);
  localparam int IW = capacity - associativity;
  localparam int TW = instruction_size - data_lines - IW;
  localparam int BW = data_lines - beat_bytes;
  localparam int CW = BW + 1;
  localparam logic [CW-1:0] NBEATS = CW'(2 ** BW);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [TW-1:0] tag_q;
  logic [IW-1:0] index_q;
  logic [BW-1:0] beat_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          last_q;

  logic          hs;
  logic          done;
  logic          accept;
  logic [BW-1:0] start;
  logic          unused_ok;

  assign hs     = valid_q & bus.addr_ready;
  assign done   = hs & last_q;
  assign accept = bus.req_valid & bus.req_ready;
  assign start  = bus.req_wrap
                ? bus.req_offset[data_lines-1:beat_bytes]
                : '0;

  // Ready in IDLE, or on the last-beat handoff for gapless bursts.
  assign bus.req_ready = ~reset & ((state == IDLE) | done);

  assign bus.addr_out   = {tag_q, index_q, beat_q,
                           {beat_bytes{1'b0}}};
  assign bus.addr_beat  = beat_q;
  assign bus.addr_valid = valid_q;
  assign bus.addr_last  = last_q;
  assign busy           = (state == BURST);

  assign unused_ok = ^bus.req_offset[beat_bytes-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (accept) begin
      state   <= BURST;
      tag_q   <= bus.req_tag;
      index_q <= bus.req_index;
      beat_q  <= start;
      cnt_q   <= NBEATS;
      valid_q <= 1'b1;
      last_q  <= (NBEATS == CW'(1));
    end else if (hs) begin
      beat_q <= beat_q + BW'(1);
      cnt_q  <= cnt_q - CW'(1);
      if (last_q) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        last_q <= (cnt_q == CW'(2));
      end
    end
  end
endmodule

// File: tb/tb_line_address_gen.sv
// Directed bench for line_address_gen: vector table of full bursts
// plus hand-written back-pressure, back-to-back and reset sequences.
module tb_line_address_gen;
  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  line_address_gen_if bus ();

  line_address_gen dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    logic [46:0] tag;
    logic [10:0] index;
    logic [5:0]  off;
    logic        wrap;
    logic [2:0]  start;
    logic [63:0] first;
    logic [63:0] last;
  } vec_t;

  vec_t tbl[5];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_cnt   = 0;

  always @(posedge clk)
    if (bus.addr_valid === 1'b1 && bus.addr_ready === 1'b1)
      hs_cnt <= hs_cnt + 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_tag    = v.tag;
    bus.req_index  = v.index;
    bus.req_offset = v.off;
    bus.req_wrap   = v.wrap;
  endtask

  function automatic logic [63:0] model(input vec_t v, input int k);
    logic [2:0] b;
    b = v.start + 3'(k);
    return {v.tag, v.index, b, 3'b000};
  endfunction

  // Called at a negedge; returns at the negedge after the last beat.
  task automatic run_vec(input vec_t v);
    drive_req(v);
    bus.addr_ready = 1'b1;
    #1 chk("acc_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("beat_valid", 64'(bus.addr_valid), 64'd1);
      chk("beat_addr", bus.addr_out, model(v, k));
      chk("beat_num", 64'(bus.addr_beat), 64'(3'(v.start + 3'(k))));
      chk("beat_last", 64'(bus.addr_last), 64'(k == 7));
      chk("beat_busy", 64'(busy), 64'd1);
      if (k == 0) chk("first_addr", bus.addr_out, v.first);
      if (k == 7) chk("last_addr", bus.addr_out, v.last);
      @(negedge clk);
    end
    chk("end_valid", 64'(bus.addr_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    bus.addr_ready = 1'b1;
    while (bus.addr_valid === 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(bus.addr_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v2;
    int   h0;

    tbl[0] = '{47'h1, 11'h005, 6'h00, 1'b0, 3'd0,
               64'h20140, 64'h20178};
    tbl[1] = '{47'h1, 11'h005, 6'h2C, 1'b1, 3'd5,
               64'h20168, 64'h20160};
    tbl[2] = '{47'h7FFF_FFFF_FFFF, 11'h7FF, 6'h00, 1'b0, 3'd0,
               64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFF8};
    tbl[3] = '{47'h1, 11'h005, 6'h2F, 1'b0, 3'd0,
               64'h20140, 64'h20178};
    tbl[4] = '{47'h2, 11'h000, 6'h3F, 1'b1, 3'd7,
               64'h40038, 64'h40030};

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_tag    = '0;
    bus.req_index  = '0;
    bus.req_offset = '0;
    bus.req_wrap   = 1'b0;
    bus.addr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_valid", 64'(bus.addr_valid), 64'd0);
    chk("rst_last", 64'(bus.addr_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", bus.addr_out, 64'd0);
    chk("rst_beat", 64'(bus.addr_beat), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Back-pressure at beat 2 for three cycles.
    h0 = hs_cnt;
    drive_req(tbl[0]);
    bus.addr_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_b0", bus.addr_out, 64'h20140);
    @(negedge clk);
    chk("bp_b1", bus.addr_out, 64'h20148);
    @(negedge clk);
    chk("bp_b2", bus.addr_out, 64'h20150);
    bus.addr_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_hold_addr", bus.addr_out, 64'h20150);
      chk("bp_hold_valid", 64'(bus.addr_valid), 64'd1);
      chk("bp_hold_beat", 64'(bus.addr_beat), 64'd2);
      chk("bp_hold_last", 64'(bus.addr_last), 64'd0);
    end
    bus.addr_ready = 1'b1;
    drain("bp_drain");
    chk("bp_handshakes", 64'(hs_cnt - h0), 64'd8);

    // Back-to-back: second request held through the first burst.
    v2 = '{47'h2, 11'h000, 6'h00, 1'b0, 3'd0, 64'h40000, 64'h40038};
    drive_req(tbl[0]);
    bus.addr_ready = 1'b1;
    @(negedge clk);
    drive_req(v2);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("b2b_ready", 64'(bus.req_ready), 64'(k == 7));
      chk("b2b_addr", bus.addr_out, model(tbl[0], k));
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b_valid", 64'(bus.addr_valid), 64'd1);
    chk("b2b_addr2", bus.addr_out, 64'h40000);
    chk("b2b_beat2", 64'(bus.addr_beat), 64'd0);
    drain("b2b_drain");

    // Reset in the middle of a burst at beat 3.
    drive_req(tbl[1]);
    bus.addr_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_beat3", bus.addr_out, 64'h20140);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_valid", 64'(bus.addr_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_addr", bus.addr_out, 64'd0);
    chk("mid_ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_ready", 64'(bus.req_ready), 64'd1);
    chk("mid_post_valid", 64'(bus.addr_valid), 64'd0);
    run_vec(tbl[2]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
